qosc_cfg_loader: RTL and testbench

- Upstream configuration stage for the quadrature oscillator core.
- Assembles byte-wide host writes from the 8-bit input pins into the five signed 16-bit operands the oscillator consumes: re_coeff, im_coeff, power, accu_re_init and accu_im_init.
- Commits a complete frame atomically to its outputs, then pulses load so the oscillator restarts from the new state.
- Host strobe and frame-clear inputs are asynchronous to clk and are synchronised inside the block.

---
 rtl/qosc_pkg.sv | 37 +++
 rtl/qosc_sync_edge.sv | 36 +++
 rtl/qosc_cfg_loader.sv | 178 +++++++++++++++++
 tb/tb_qosc_cfg_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qosc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qosc_pkg
// Brief   : Shared types and constants for the quadrature oscillator
//           configuration path and the oscillator core.
// Revision: 1.0 - initial release
// ============================================================================
package qosc_pkg;

  // Frame layout: five 16-bit words, each sent MSB first
  localparam int unsigned NUM_WORDS   = 5;
  localparam int unsigned FRAME_BYTES = 10;

  // Word slots inside a frame, in transmission order
  localparam int unsigned W_RE_COEFF = 0;
  localparam int unsigned W_IM_COEFF = 1;
  localparam int unsigned W_POWER    = 2;
  localparam int unsigned W_RE_INIT  = 3;
  localparam int unsigned W_IM_INIT  = 4;

  // Operand type consumed by the oscillator core
  typedef logic signed [15:0] sample_t;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOAD    = 2'd2
  } state_e;

  // Byte k of a frame lands in word k/2
  function automatic logic [2:0] word_idx(input logic [3:0] byte_idx);
    return byte_idx[3:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/qosc_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : qosc_sync_edge
// Brief   : Multi-flop synchroniser for an asynchronous level plus a
//           single-cycle rising-edge detector on the synchronised value.
// Revision: 1.0 - initial release
// ============================================================================
module qosc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchroniser chain and keep the previous output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/qosc_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : qosc_cfg_loader
// Brief   : Collects byte-wide host writes into five signed 16-bit operands,
//           commits a complete frame atomically and pulses load so the
//           oscillator restarts from the new state.
// Revision: 1.0 - initial release
// ============================================================================
module qosc_cfg_loader
  import qosc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOAD_CYCLES = 1,
  parameter int FRAME_BYTES = qosc_pkg::FRAME_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data_in,
  input  logic       i_strobe,
  input  logic       i_frame_clr,
  output sample_t    o_re_coeff,
  output sample_t    o_im_coeff,
  output sample_t    o_power,
  output sample_t    o_accu_re_init,
  output sample_t    o_accu_im_init,
  output logic       o_load,
  output logic [3:0] o_byte_cnt,
  output logic       o_frame_done
);

  // Reject parameter values the frame format and counters cannot support
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("qosc_cfg_loader: SYNC_STAGES must be at least 2");
  end
  if ((LOAD_CYCLES < 1) || (LOAD_CYCLES > 15)) begin : g_bad_load_cycles
    $error("qosc_cfg_loader: LOAD_CYCLES must be in 1..15");
  end
  if (FRAME_BYTES != 10) begin : g_bad_frame_bytes
    $error("qosc_cfg_loader: FRAME_BYTES must be 10");
  end

  logic       w_stb_rise;
  logic       w_stb_level;
  logic       w_clr_level;
  logic       w_unused_clr_rise;
  logic       w_unused_stb_level;
  logic       w_capture;
  logic       w_last_byte;
  logic [2:0] w_wr_idx;
  logic [3:0] w_byte_cnt_nxt;
  state_e     w_state_nxt;

  state_e     r_state;
  logic [3:0] r_byte_cnt;
  logic [3:0] r_load_cnt;
  logic       r_commit_pend;
  logic       r_frame_done;
  sample_t    r_shadow [NUM_WORDS];
  sample_t    r_word   [NUM_WORDS];

  qosc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_strobe (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_strobe),
    .o_level (w_unused_stb_level),
    .o_rise  (w_stb_rise)
  );

  qosc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_clr (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_frame_clr),
    .o_level (w_clr_level),
    .o_rise  (w_unused_clr_rise)
  );

  // A clear level suppresses any capture detected in the same cycle
  assign w_capture   = w_stb_rise & ~w_clr_level;
  assign w_last_byte = w_capture && (r_byte_cnt == 4'(FRAME_BYTES - 1));
  assign w_wr_idx    = word_idx(r_byte_cnt);

  // Byte counter: cleared by frame_clr, wraps to zero once the frame is full
  always_comb begin
    w_byte_cnt_nxt = r_byte_cnt;
    if (w_clr_level) begin
      w_byte_cnt_nxt = 4'd0;
    end else if (w_capture) begin
      w_byte_cnt_nxt = w_last_byte ? 4'd0 : (r_byte_cnt + 4'd1);
    end
  end

  // Next-state logic; a pending commit always proceeds into LOAD
  always_comb begin
    w_state_nxt = r_state;
    if (r_commit_pend) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            w_state_nxt = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_clr_level) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (r_load_cnt == 4'd0) begin
            w_state_nxt = (w_byte_cnt_nxt != 4'd0) ? ST_COLLECT : ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte capture into the shadow words; the last byte arms the commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt    <= 4'd0;
      r_commit_pend <= 1'b0;
      r_shadow      <= '{default: '0};
    end else begin
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_commit_pend <= w_last_byte;
      if (w_capture) begin
        if (!r_byte_cnt[0]) begin
          r_shadow[w_wr_idx][15:8] <= i_data_in;
        end else begin
          r_shadow[w_wr_idx][7:0] <= i_data_in;
        end
      end
    end
  end

  // Commit: copy all shadow words at once and time the load pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word       <= '{default: '0};
      r_frame_done <= 1'b0;
      r_load_cnt   <= 4'd0;
    end else begin
      r_frame_done <= r_commit_pend;
      if (r_commit_pend) begin
        r_word     <= r_shadow;
        r_load_cnt <= 4'(LOAD_CYCLES - 1);
      end else if ((r_state == ST_LOAD) && (r_load_cnt != 4'd0)) begin
        r_load_cnt <= r_load_cnt - 4'd1;
      end
    end
  end

  assign o_re_coeff     = r_word[W_RE_COEFF];
  assign o_im_coeff     = r_word[W_IM_COEFF];
  assign o_power        = r_word[W_POWER];
  assign o_accu_re_init = r_word[W_RE_INIT];
  assign o_accu_im_init = r_word[W_IM_INIT];
  assign o_load         = (r_state == ST_LOAD);
  assign o_byte_cnt     = r_byte_cnt;
  assign o_frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_qosc_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_qosc_cfg_loader
// Brief   : Self-checking bench for qosc_cfg_loader. Two instances (load
//           pulse of 1 and 4 cycles) share one stimulus stream; a byte-level
//           reference model predicts every output on every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qosc_cfg_loader;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       strobe = 1'b0;
  logic       frame_clr = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [15:0] d1_re, d1_im, d1_pw, d1_ar, d1_ai;
  logic [15:0] d4_re, d4_im, d4_pw, d4_ar, d4_ai;
  logic        d1_load, d4_load, d1_fd, d4_fd;
  logic [3:0]  d1_cnt, d4_cnt;
  logic [79:0] d1_words, d4_words;

  assign d1_words = {d1_re, d1_im, d1_pw, d1_ar, d1_ai};
  assign d4_words = {d4_re, d4_im, d4_pw, d4_ar, d4_ai};

  always #5 clk = ~clk;

  qosc_cfg_loader #(.SYNC_STAGES(SS), .LOAD_CYCLES(1), .FRAME_BYTES(10)) u_dut1 (
    .clk(clk), .rst(rst), .i_data_in(data_in), .i_strobe(strobe), .i_frame_clr(frame_clr),
    .o_re_coeff(d1_re), .o_im_coeff(d1_im), .o_power(d1_pw),
    .o_accu_re_init(d1_ar), .o_accu_im_init(d1_ai),
    .o_load(d1_load), .o_byte_cnt(d1_cnt), .o_frame_done(d1_fd)
  );

  qosc_cfg_loader #(.SYNC_STAGES(SS), .LOAD_CYCLES(4), .FRAME_BYTES(10)) u_dut4 (
    .clk(clk), .rst(rst), .i_data_in(data_in), .i_strobe(strobe), .i_frame_clr(frame_clr),
    .o_re_coeff(d4_re), .o_im_coeff(d4_im), .o_power(d4_pw),
    .o_accu_re_init(d4_ar), .o_accu_im_init(d4_ai),
    .o_load(d4_load), .o_byte_cnt(d4_cnt), .o_frame_done(d4_fd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin history per cycle; a pin change in cycle n is seen by capture logic
  // at edge n+SS+1, clear wins over a simultaneous rise.
  int          cyc = 16;
  bit          s_hist [64];
  bit          c_hist [64];
  logic [7:0]  m_bytes [10];
  logic [15:0] m_words [5];
  int          m_cnt = 0;
  bit          m_pend = 0;
  bit          m_fd = 0;
  int          m_ll1 = 0;
  int          m_ll4 = 0;
  int          last_rise = 0;

  // Record the pin levels held during the current cycle
  always @(negedge clk) begin
    s_hist[cyc % 64] = strobe;
    c_hist[cyc % 64] = frame_clr;
  end

  // Advance the model by one clock edge
  always @(posedge clk) begin : p_model
    bit cap;
    bit clr_e;
    cyc++;
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_fd = 0; m_ll1 = 0; m_ll4 = 0;
      for (int w = 0; w < 5; w++) m_words[w] = 16'h0000;
      for (int b = 0; b < 10; b++) m_bytes[b] = 8'h00;
      for (int k = 0; k < 8; k++) begin
        s_hist[(cyc - k) % 64] = 1'b0;
        c_hist[(cyc - k) % 64] = 1'b0;
      end
    end else begin
      clr_e = c_hist[(cyc - 1 - SS) % 64];
      cap   = s_hist[(cyc - 1 - SS) % 64] && !s_hist[(cyc - 2 - SS) % 64] && !clr_e;
      if (m_ll1 > 0) m_ll1--;
      if (m_ll4 > 0) m_ll4--;
      m_fd = 0;
      if (m_pend) begin
        for (int w = 0; w < 5; w++) m_words[w] = {m_bytes[2*w], m_bytes[2*w+1]};
        m_fd = 1; m_ll1 = 1; m_ll4 = 4; m_pend = 0;
      end
      if (clr_e) begin
        m_cnt = 0;
      end else if (cap) begin
        m_bytes[m_cnt] = data_in;
        if (m_cnt == 9) begin
          m_cnt = 0; m_pend = 1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  bit chk_en = 0;

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic [79:0] ew;
      ew = rst ? 80'h0 : {m_words[0], m_words[1], m_words[2], m_words[3], m_words[4]};
      chk("dut1 words",      d1_words, ew);
      chk("dut1 byte_cnt",   d1_cnt,   rst ? 0 : m_cnt);
      chk("dut1 load",       d1_load,  (!rst && m_ll1 > 0));
      chk("dut1 frame_done", d1_fd,    (!rst && m_fd));
      chk("dut4 words",      d4_words, ew);
      chk("dut4 byte_cnt",   d4_cnt,   rst ? 0 : m_cnt);
      chk("dut4 load",       d4_load,  (!rst && m_ll4 > 0));
      chk("dut4 frame_done", d4_fd,    (!rst && m_fd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 data_in = b;
    @(posedge clk); #1 strobe = 1'b1; last_rise = cyc;
    @(posedge clk);
    @(posedge clk); #1 strobe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b [10]);
    for (int i = 0; i < 10; i++) send_byte(b[i]);
  endtask

  // Wait (bounded) for the commit pulse and check its latency
  task automatic wait_fd(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d1_fd) begin
        at = cyc;
        break;
      end
    end
    chk("frame_done seen", (at >= 0), 1);
    chk("commit latency", at - last_rise, SS + 2);
  endtask

  typedef struct {
    bit          abort;
    logic [7:0]  b [10];
    logic [79:0] exp;
  } vec_t;

  vec_t vt [4];

  initial begin : p_main
    int          at;
    int          nload;
    int          got;
    logic [7:0]  f [10];
    logic [7:0]  stream [20];
    logic [79:0] sb [$];
    logic [79:0] expw;

    vt[0].abort = 0;
    vt[0].b     = '{8'h7F, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    vt[0].exp   = 80'h7FFF_0000_4000_2000_0000;
    vt[1].abort = 0;
    vt[1].b     = '{default: 8'hA5};
    vt[1].exp   = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
    vt[2].abort = 1;
    vt[2].b     = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22};
    vt[2].exp   = 80'h1234_5678_9ABC_DEF0_1122;
    vt[3].abort = 0;
    vt[3].b     = '{8'h80, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h80};
    vt[3].exp   = 80'h8000_FFFF_8001_0001_FF80;

    #1 rst = 1'b1;
    chk_en = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset words", d1_words, 80'h0);
    chk("reset load/fd/cnt", {d4_load, d4_fd, d4_cnt}, 6'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      if (vt[i].abort) begin
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        @(posedge clk); #1 frame_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 frame_clr = 1'b0;
        repeat (SS + 3) @(negedge clk);
        chk("byte_cnt after clr", {d1_cnt, d4_cnt}, 8'h00);
      end
      send_frame(vt[i].b);
      wait_fd(at);
      chk("table words dut1", d1_words, vt[i].exp);
      nload = 0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        if (d4_load) begin
          nload++;
          chk("dut4 words stable under load", d4_words, vt[i].exp);
        end
      end
      chk("dut4 load length", nload, 4);
    end

    // Strobe rise coincident with frame_clr assertion: byte dropped
    for (int k = 0; k < 3; k++) send_byte(8'h3C);
    @(posedge clk); #1 data_in = 8'hEE;
    @(posedge clk); #1 strobe = 1'b1; frame_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 frame_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 strobe = 1'b0;
    repeat (SS + 3) @(negedge clk);
    chk("byte_cnt after simultaneous clr", {d1_cnt, d4_cnt}, 8'h00);

    // First byte of the next frame detected in the commit cycle
    for (int k = 0; k < 10; k++) f[k] = 8'($urandom);
    expw = {f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7], f[8], f[9]};
    for (int k = 0; k < 9; k++) send_byte(f[k]);
    @(posedge clk); #1 data_in = f[9];
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 data_in = 8'h5A;
    @(negedge clk);
    chk("no commit before commit edge", d1_fd, 0);
    @(negedge clk);
    chk("commit cycle fd/cnt", {d1_fd, d1_cnt, d4_fd, d4_cnt}, 10'b1_0000_1_0000);
    chk("commit cycle words", d1_words, expw);
    @(posedge clk); #1 strobe = 1'b0;
    @(negedge clk);
    chk("byte_cnt after commit-cycle rise", {d1_cnt, d4_cnt}, 8'h11);
    chk("outputs hold committed frame", d4_words, expw);
    for (int k = 0; k < 9; k++) send_byte(8'(k * 17 + 3));
    wait_fd(at);
    chk("frame started in commit cycle", d1_words,
        {8'h5A, 8'd3, 8'd20, 8'd37, 8'd54, 8'd71, 8'd88, 8'd105, 8'd122, 8'd139});
    repeat (6) @(posedge clk);

    // Back-to-back: 20 bytes at the maximum rate against a frame scoreboard
    for (int k = 0; k < 20; k++) stream[k] = 8'($urandom);
    sb.push_back({stream[0], stream[1], stream[2], stream[3], stream[4],
                  stream[5], stream[6], stream[7], stream[8], stream[9]});
    sb.push_back({stream[10], stream[11], stream[12], stream[13], stream[14],
                  stream[15], stream[16], stream[17], stream[18], stream[19]});
    got = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send_byte(stream[k]);
      end
      begin
        int guard;
        guard = 0;
        while (got < 2 && guard < 200) begin
          @(negedge clk);
          guard++;
          if (d1_fd) begin
            chk("scoreboard frame", d1_words, sb.pop_front());
            got++;
          end
        end
      end
    join
    chk("scoreboard commits", got, 2);
    repeat (6) @(posedge clk);

    // Random bytes with random gaps and occasional clears, model-checked
    for (int k = 0; k < 40; k++) begin
      send_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1 frame_clr = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1 frame_clr = 1'b0;
      end
    end
    repeat (10) @(posedge clk);

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) send_byte(8'hC3);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("async reset mid-frame", {d1_cnt, d4_cnt, d4_words}, 88'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Reset during a long load pulse
    send_frame(vt[0].b);
    wait_fd(at);
    chk("dut4 load high before reset", d4_load, 1);
    #2 rst = 1'b1;
    #1 chk("async reset mid-load", {d4_load, d1_load, d4_words, d1_words}, 162'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(vt[3].b);
    wait_fd(at);
    chk("frame after reset", d4_words, vt[3].exp);
    repeat (6) @(posedge clk);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
